i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- I2S transmitter, the consumer end of the NCO audio path. Accepts stereo samples through a valid/ready handshake into a one-entry holding register.
- Serialises each sample as a standard Philips I2S frame to the external DAC.
- Generates bclk_o and lrclk_o from clk_i.
- Emits frame_start_o once per frame, so upstream sample generation can be paced by the DAC frame rather than a free-running tick.

Parameters:
- AUDIO_BITS, 24, sample width per channel.
- SLOT_BITS, 32, bclk periods per channel slot; must be >= AUDIO_BITS+1.
- BCLK_DIV, 2, clk_i cycles per bclk half-period; must be >= 1.
- Frame rate is CLK_FREQ/(4*BCLK_DIV*SLOT_BITS). At 12 MHz with defaults this gives 256 clk_i cycles per frame, 46.875 kHz. The NCO FS parameter must match this rate.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- sample_l_i  in  AUDIO_BITS  left sample, two's complement
- sample_r_i  in  AUDIO_BITS  right sample, two's complement
- valid_i  in  1  sample pair valid
- ready_o  out  1  holding register empty; transfer occurs when valid_i && ready_o at a clk_i edge
- bclk_o  out  1  bit clock
- lrclk_o  out  1  word select: 0 = left, 1 = right
- sdata_o  out  1  serial data, changes on bclk falling edge
- frame_start_o  out  1  one-cycle pulse in the frame load cycle
- underrun_o  out  1  sticky underrun flag

Behaviour:
- Reset values (rst_i high at an edge):
  - div_cnt=0, bclk_o=0, bit_cnt=2*SLOT_BITS-1, lrclk_o=1, sdata_o=0.
  - hold_full=0, so ready_o=1.
  - frame regs=0, frame_start_o=0, underrun_o=0.
  - Reset mid-frame aborts the frame immediately; any held sample is discarded.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1.
  - On wrap, bclk_o toggles.
  - A 1->0 toggle is a "fall cycle". All serial outputs update only in fall cycles, registered, in the same edge as bclk_o.
- Fall cycle:
  - bit_cnt increments mod 2*SLOT_BITS.
  - Slot position j = new bit_cnt mod SLOT_BITS.
  - lrclk_o = (new bit_cnt >= SLOT_BITS).
  - sdata_o = slot sample bit [AUDIO_BITS-j] for 1<=j<=AUDIO_BITS, else 0. The MSB is one bclk after the lrclk edge; zero padding follows the LSB.
- Frame load (fall cycle where new bit_cnt=0):
  - frame_start_o=1 for that cycle.
  - If hold_full was 1 before the edge: frame regs <= holding register, hold_full <= 0.
  - Otherwise it is an underrun: underrun_o <= 1, and the frame regs follow the Optional Feature.
- Handshake:
  - ready_o = !hold_full, registered.
  - On accept, the holding register captures both channels and hold_full <= 1.
  - An accept in the load cycle itself is legal. The load decision uses the pre-edge hold_full, so the new pair is retained for the next frame.
  - ready_o reasserts the cycle after the load.
  - No combinational path from valid_i to ready_o.
- Timing:
  - First frame_start_o occurs at the 2*BCLK_DIV-th edge after rst_i deasserts.
  - Latency from accept to left MSB on sdata_o: the next frame load plus 2*BCLK_DIV cycles.
- underrun_o clears only on reset.

Optional Feature:
- Macro I2S_TX_MUTE_ON_UNDERRUN_EN.
- Defined: an underrun frame loads zeros into both channels.
- Undefined: an underrun frame repeats the previous frame's samples. After reset, with no sample yet accepted, that is zeros.
- underrun_o behaviour is identical either way.

Test Plan:
- Hold rst_i high 5 cycles, then sample outputs -> bclk_o=0, lrclk_o=1, sdata_o=0, ready_o=1, frame_start_o=0, underrun_o=0; first frame_start_o pulse on the 4th edge after release.
- Accept L=24'hA55AF0, R=24'h0FF001 before the first load; capture sdata_o on 64 bclk rising edges:
  - Left slot: 0, A55AF0 MSB-first, 7 zeros, with lrclk_o=0.
  - Right slot: 0, 0FF001, 7 zeros, with lrclk_o=1.
  - underrun_o stays 0.
- Free run with valid_i held high -> bclk_o period 4 cycles, 50% duty; frame_start_o exactly every 256 cycles; lrclk_o toggles every 128 cycles, always on a bclk_o falling edge.
- Present pairs P1 then P2 back-to-back with valid_i held high:
  - P1 accepted immediately; ready_o=0 until the cycle after the next frame_start_o; P2 accepted then.
  - P1 sent in that frame, P2 in the following frame.
- Stop valid_i after P1 -> next frame sets underrun_o=1 and it stays 1. Macro undefined: P1 retransmitted. Macro defined: all 64 sdata_o bits 0.
- Assert rst_i at left-slot bit 10 with a pair held -> reset values on the next edge, held pair lost, ready_o=1; the next frame_start_o occurs 4 cycles after release.

Source files
------------

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: one-entry sample holding register, bclk/lrclk generation, frame pacing.
// Build option: define I2S_TX_MUTE_ON_UNDERRUN_EN to send silence (instead of repeating) on underrun.
module i2s_tx #(
  parameter int AUDIO_BITS = 24,
  parameter int SLOT_BITS  = 32,
  parameter int BCLK_DIV   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [AUDIO_BITS-1:0] sample_l_i,
  input  logic [AUDIO_BITS-1:0] sample_r_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  bclk_o,
  output logic                  lrclk_o,
  output logic                  sdata_o,
  output logic                  frame_start_o,
  output logic                  underrun_o
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0]      div_cnt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      bit_cnt_nxt;
  logic [CNT_W-1:0]      slot_pos;
  logic                  div_wrap;
  logic                  fall;
  logic                  load;
  logic                  accept;
  logic                  lrclk_nxt;
  logic                  sdata_nxt;
  logic                  hold_full;
  logic                  hold_full_nxt;
  logic [AUDIO_BITS-1:0] hold_l, hold_r;
  logic [AUDIO_BITS-1:0] frame_l, frame_r;
  logic [AUDIO_BITS-1:0] slot_sample;
  logic [AUDIO_BITS-1:0] shifted;

  assign div_wrap = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign fall     = div_wrap & bclk_o;
  assign accept   = valid_i & ready_o;

  // The load decision looks at hold_full before this edge, so a pair accepted
  // in the load cycle itself is kept for the following frame.
  assign load          = fall & (bit_cnt_nxt == '0);
  assign hold_full_nxt = accept | (hold_full & ~load);

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    bit_cnt_nxt = (bit_cnt == CNT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + CNT_W'(1);
    lrclk_nxt   = (bit_cnt_nxt >= CNT_W'(SLOT_BITS));
    slot_pos    = lrclk_nxt ? bit_cnt_nxt - CNT_W'(SLOT_BITS) : bit_cnt_nxt;
    slot_sample = lrclk_nxt ? frame_r : frame_l;
    shifted     = '0;
    sdata_nxt   = 1'b0;
    // Slot position 0 is the one-bclk I2S delay; positions past the LSB are zero padding.
    if (slot_pos != '0 && slot_pos <= CNT_W'(AUDIO_BITS)) begin
      shifted   = slot_sample << (slot_pos - CNT_W'(1));
      sdata_nxt = shifted[AUDIO_BITS-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt       <= '0;
      bclk_o        <= 1'b0;
      bit_cnt       <= CNT_W'(FRAME_BITS - 1);
      lrclk_o       <= 1'b1;
      sdata_o       <= 1'b0;
      frame_start_o <= 1'b0;
      underrun_o    <= 1'b0;
      hold_full     <= 1'b0;
      ready_o       <= 1'b1;
      // NOTE: sample registers are reset too, so a reset discards the held pair and the
      // first underrun frame repeats a defined value (zeros).
      hold_l        <= '0;
      hold_r        <= '0;
      frame_l       <= '0;
      frame_r       <= '0;
    end else begin
      div_cnt       <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      frame_start_o <= load;
      hold_full     <= hold_full_nxt;
      ready_o       <= ~hold_full_nxt;

      if (div_wrap) bclk_o <= ~bclk_o;

      if (fall) begin
        bit_cnt <= bit_cnt_nxt;
        lrclk_o <= lrclk_nxt;
        sdata_o <= sdata_nxt;
      end

      if (load) begin
        if (hold_full) begin
          frame_l <= hold_l;
          frame_r <= hold_r;
        end else begin
          underrun_o <= 1'b1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
          frame_l <= '0;
          frame_r <= '0;
`else
          frame_l <= frame_l;
          frame_r <= frame_r;
`endif
        end
      end

      if (accept) begin
        hold_l <= sample_l_i;
        hold_r <= sample_r_i;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: randomized sample pairs checked against a frame-level model
// of the I2S slot layout, plus clock-ratio, handshake, underrun and reset scenarios.
module tb_i2s_tx;

  localparam int AUDIO_BITS = 24;
  localparam int SLOT_BITS  = 32;
  localparam int BCLK_DIV   = 2;
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int FRAME_CYC  = 2 * BCLK_DIV * FRAME_BITS;

  typedef logic [AUDIO_BITS-1:0] sample_t;
  typedef logic [FRAME_BITS-1:0] frame_t;

  logic    clk_i = 1'b0;
  logic    rst_i;
  sample_t sample_l_i, sample_r_i;
  logic    valid_i;
  logic    ready_o, bclk_o, lrclk_o, sdata_o, frame_start_o, underrun_o;

  i2s_tx #(
    .AUDIO_BITS(AUDIO_BITS),
    .SLOT_BITS (SLOT_BITS),
    .BCLK_DIV  (BCLK_DIV)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .sample_l_i   (sample_l_i),
    .sample_r_i   (sample_r_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .bclk_o       (bclk_o),
    .lrclk_o      (lrclk_o),
    .sdata_o      (sdata_o),
    .frame_start_o(frame_start_o),
    .underrun_o   (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  int      tests_run    = 0;
  int      tests_failed = 0;
  int      cycle        = 0;
  int      fs_cycle     = 0;
  logic    autofeed     = 1'b0;
  sample_t feed_l[$];
  sample_t feed_r[$];
  int      acc_cycles[$];

  // Expected serial stream for one frame, first transmitted bit in the MSB position.
  function automatic frame_t frame_bits(input sample_t l, input sample_t r);
    frame_t  res;
    sample_t s, t;
    int      j;
    res = '0;
    for (int k = 0; k < FRAME_BITS; k++) begin
      j = k % SLOT_BITS;
      s = (k < SLOT_BITS) ? l : r;
      if (j >= 1 && j <= AUDIO_BITS) begin
        t = s >> (AUDIO_BITS - j);
        res[FRAME_BITS-1-k] = t[0];
      end
    end
    return res;
  endfunction

  function automatic frame_t lr_bits();
    return {{SLOT_BITS{1'b0}}, {SLOT_BITS{1'b1}}};
  endfunction

  task automatic present_next();
    if (autofeed) begin
      valid_i    = 1'b1;
      sample_l_i = sample_t'($urandom);
      sample_r_i = sample_t'($urandom);
    end else if (feed_l.size() > 0) begin
      valid_i    = 1'b1;
      sample_l_i = feed_l.pop_front();
      sample_r_i = feed_r.pop_front();
    end else begin
      valid_i = 1'b0;
    end
  endtask

  // One clock; outputs are observed 1 time unit after the rising edge.
  task automatic step();
    logic acc;
    acc = valid_i && ready_o && !rst_i;
    @(posedge clk_i);
    #1;
    cycle++;
    if (acc) begin
      acc_cycles.push_back(cycle);
      present_next();
    end
  endtask

  task automatic push_pair(input sample_t l, input sample_t r);
    feed_l.push_back(l);
    feed_r.push_back(r);
  endtask

  task automatic do_reset();
    rst_i    = 1'b1;
    valid_i  = 1'b0;
    autofeed = 1'b0;
    feed_l.delete();
    feed_r.delete();
    acc_cycles.delete();
    repeat (3) step();
    rst_i = 1'b0;
    cycle = 0;
  endtask

  task automatic wait_frame_start(output int n);
    n = 0;
    while (frame_start_o !== 1'b1 && n < 2 * FRAME_CYC) begin
      step();
      n++;
    end
    if (frame_start_o !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL frame_start_timeout: no pulse within %0d cycles", n);
    end
    fs_cycle = cycle;
  endtask

  task automatic capture_bits(output frame_t d, output frame_t lr);
    int   got   = 0;
    int   guard = 0;
    logic prev_b;
    d      = '0;
    lr     = '0;
    prev_b = bclk_o;
    while (got < FRAME_BITS && guard < 2 * FRAME_CYC) begin
      step();
      guard++;
      if (bclk_o && !prev_b) begin
        d[FRAME_BITS-1-got]  = sdata_o;
        lr[FRAME_BITS-1-got] = lrclk_o;
        got++;
      end
      prev_b = bclk_o;
    end
    if (got != FRAME_BITS) begin
      tests_run++;
      tests_failed++;
      $display("FAIL capture_timeout: got %0d bclk rises, need %0d", got, FRAME_BITS);
    end
  endtask

  task automatic capture_frame(output frame_t d, output frame_t lr);
    int n;
    wait_frame_start(n);
    capture_bits(d, lr);
  endtask

  task automatic test_reset();
    int n;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    repeat (5) step();
    tests_run++;
    if ({bclk_o, lrclk_o, sdata_o, ready_o, frame_start_o, underrun_o} !== 6'b010100) begin
      tests_failed++;
      $display("FAIL reset_outputs: {bclk,lrclk,sdata,ready,fs,ur} got %b exp 010100",
               {bclk_o, lrclk_o, sdata_o, ready_o, frame_start_o, underrun_o});
    end
    rst_i = 1'b0;
    cycle = 0;
    wait_frame_start(n);
    tests_run++;
    if (n != 2 * BCLK_DIV) begin
      tests_failed++;
      $display("FAIL first_frame_start: edge %0d after release, exp %0d", n, 2 * BCLK_DIV);
    end
  endtask

  task automatic test_frame_data();
    frame_t  d, lr, exp;
    sample_t l2, r2;
    do_reset();
    push_pair(24'hA55AF0, 24'h0FF001);
    present_next();
    capture_frame(d, lr);
    exp = frame_bits(24'hA55AF0, 24'h0FF001);
    tests_run++;
    if (d !== exp) begin
      tests_failed++;
      $display("FAIL fixed_frame_data: got %h exp %h", d, exp);
    end
    tests_run++;
    if (lr !== lr_bits()) begin
      tests_failed++;
      $display("FAIL fixed_frame_lrclk: got %h exp %h", lr, lr_bits());
    end
    tests_run++;
    if (underrun_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL fixed_frame_underrun: got %b exp 0", underrun_o);
    end
    for (int i = 0; i < 2; i++) begin
      l2 = sample_t'($urandom);
      r2 = sample_t'($urandom);
      push_pair(l2, r2);
      present_next();
      capture_frame(d, lr);
      exp = frame_bits(l2, r2);
      tests_run++;
      if (d !== exp || lr !== lr_bits()) begin
        tests_failed++;
        $display("FAIL random_frame%0d: data %h exp %h, lrclk %h exp %h", i, d, exp, lr, lr_bits());
      end
    end
    tests_run++;
    if (underrun_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL random_frame_underrun: got %b exp 0", underrun_o);
    end
  endtask

  task automatic test_free_run();
    int   last_rise = -1, last_fall = -1, last_fs = -1, last_lr = -1;
    int   rises = 0, fs_cnt = 0, lr_cnt = 0;
    int   bad_period = 0, bad_duty = 0, bad_fs = 0, bad_lr = 0, bad_lr_edge = 0;
    logic prev_b, prev_lr, fell;
    do_reset();
    autofeed = 1'b1;
    present_next();
    step();
    prev_b  = bclk_o;
    prev_lr = lrclk_o;
    repeat (1200) begin
      step();
      fell = !bclk_o && prev_b;
      if (bclk_o && !prev_b) begin
        if (last_rise >= 0 && cycle - last_rise != 2 * BCLK_DIV) bad_period++;
        if (last_fall >= 0 && cycle - last_fall != BCLK_DIV) bad_duty++;
        last_rise = cycle;
        rises++;
      end
      if (fell) begin
        if (last_rise >= 0 && cycle - last_rise != BCLK_DIV) bad_duty++;
        last_fall = cycle;
      end
      if (frame_start_o) begin
        if (last_fs >= 0 && cycle - last_fs != FRAME_CYC) bad_fs++;
        last_fs = cycle;
        fs_cnt++;
      end
      if (lrclk_o !== prev_lr) begin
        if (!fell) bad_lr_edge++;
        if (last_lr >= 0 && cycle - last_lr != FRAME_CYC / 2) bad_lr++;
        last_lr = cycle;
        lr_cnt++;
      end
      prev_b  = bclk_o;
      prev_lr = lrclk_o;
    end
    tests_run++;
    if (bad_period != 0 || rises != 1200 / (2 * BCLK_DIV)) begin
      tests_failed++;
      $display("FAIL bclk_period: %0d bad periods, %0d rises exp %0d", bad_period, rises,
               1200 / (2 * BCLK_DIV));
    end
    tests_run++;
    if (bad_duty != 0) begin
      tests_failed++;
      $display("FAIL bclk_duty: %0d bad half-periods, exp 0", bad_duty);
    end
    tests_run++;
    if (bad_fs != 0 || fs_cnt < 1200 / FRAME_CYC) begin
      tests_failed++;
      $display("FAIL frame_period: %0d bad intervals, %0d pulses exp >= %0d", bad_fs, fs_cnt,
               1200 / FRAME_CYC);
    end
    tests_run++;
    if (bad_lr != 0 || lr_cnt < 1200 / (FRAME_CYC / 2)) begin
      tests_failed++;
      $display("FAIL lrclk_period: %0d bad intervals, %0d toggles exp >= %0d", bad_lr, lr_cnt,
               1200 / (FRAME_CYC / 2));
    end
    tests_run++;
    if (bad_lr_edge != 0) begin
      tests_failed++;
      $display("FAIL lrclk_on_bclk_fall: %0d toggles off a bclk fall, exp 0", bad_lr_edge);
    end
    tests_run++;
    if (underrun_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL free_run_underrun: got %b exp 0", underrun_o);
    end
    autofeed = 1'b0;
    valid_i  = 1'b0;
  endtask

  task automatic test_back_to_back();
    frame_t  d1, d2, lr;
    sample_t l1, r1, l2, r2;
    int      first_fs;
    l1 = sample_t'($urandom);
    r1 = sample_t'($urandom);
    l2 = sample_t'($urandom);
    r2 = sample_t'($urandom);
    do_reset();
    push_pair(l1, r1);
    push_pair(l2, r2);
    present_next();
    capture_frame(d1, lr);
    first_fs = fs_cycle;
    capture_frame(d2, lr);
    tests_run++;
    if (acc_cycles.size() != 2) begin
      tests_failed++;
      $display("FAIL b2b_accept_count: got %0d exp 2", acc_cycles.size());
    end else if (acc_cycles[0] != 1 || acc_cycles[1] != first_fs + 1) begin
      tests_failed++;
      $display("FAIL b2b_accept_cycles: got %0d,%0d exp 1,%0d", acc_cycles[0], acc_cycles[1],
               first_fs + 1);
    end
    tests_run++;
    if (d1 !== frame_bits(l1, r1)) begin
      tests_failed++;
      $display("FAIL b2b_frame_p1: got %h exp %h", d1, frame_bits(l1, r1));
    end
    tests_run++;
    if (d2 !== frame_bits(l2, r2)) begin
      tests_failed++;
      $display("FAIL b2b_frame_p2: got %h exp %h", d2, frame_bits(l2, r2));
    end
    tests_run++;
    if (underrun_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_underrun: got %b exp 0", underrun_o);
    end
  endtask

  task automatic test_underrun();
    frame_t  d, lr, exp;
    sample_t l1, r1;
    l1 = sample_t'($urandom);
    r1 = sample_t'($urandom);
    do_reset();
    push_pair(l1, r1);
    present_next();
    capture_frame(d, lr);
    tests_run++;
    if (d !== frame_bits(l1, r1) || underrun_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL underrun_setup: data %h exp %h, underrun %b exp 0", d, frame_bits(l1, r1),
               underrun_o);
    end
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
    exp = '0;
`else
    exp = frame_bits(l1, r1);
`endif
    for (int i = 0; i < 2; i++) begin
      capture_frame(d, lr);
      tests_run++;
      if (d !== exp) begin
        tests_failed++;
        $display("FAIL underrun_frame%0d: got %h exp %h", i, d, exp);
      end
      tests_run++;
      if (underrun_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL underrun_flag%0d: got %b exp 1", i, underrun_o);
      end
    end
  endtask

  task automatic test_reset_midframe();
    frame_t d, lr;
    int     n, rises, guard;
    logic   prev_b;
    do_reset();
    push_pair(sample_t'($urandom), sample_t'($urandom));
    push_pair(sample_t'($urandom), sample_t'($urandom));
    present_next();
    wait_frame_start(n);
    // Eleventh bclk rise after the load is left-slot bit 10.
    rises  = 0;
    guard  = 0;
    prev_b = bclk_o;
    while (rises < 11 && guard < FRAME_CYC) begin
      step();
      guard++;
      if (bclk_o && !prev_b) rises++;
      prev_b = bclk_o;
    end
    tests_run++;
    if (ready_o !== 1'b0 || rises != 11) begin
      tests_failed++;
      $display("FAIL midframe_pair_held: ready %b exp 0, rises %0d exp 11", ready_o, rises);
    end
    rst_i   = 1'b1;
    valid_i = 1'b0;
    step();
    tests_run++;
    if ({bclk_o, lrclk_o, sdata_o, ready_o, frame_start_o, underrun_o} !== 6'b010100) begin
      tests_failed++;
      $display("FAIL midframe_reset_outputs: got %b exp 010100",
               {bclk_o, lrclk_o, sdata_o, ready_o, frame_start_o, underrun_o});
    end
    rst_i = 1'b0;
    cycle = 0;
    wait_frame_start(n);
    tests_run++;
    if (n != 2 * BCLK_DIV) begin
      tests_failed++;
      $display("FAIL midframe_restart: frame_start after %0d edges exp %0d", n, 2 * BCLK_DIV);
    end
    tests_run++;
    if (underrun_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL midframe_pair_lost: underrun %b exp 1", underrun_o);
    end
    capture_bits(d, lr);
    tests_run++;
    if (d !== '0) begin
      tests_failed++;
      $display("FAIL midframe_frame_zero: got %h exp 0", d);
    end
  endtask

  initial begin
    rst_i      = 1'b1;
    valid_i    = 1'b0;
    sample_l_i = '0;
    sample_r_i = '0;
    test_reset();
    test_frame_data();
    test_free_run();
    test_back_to_back();
    test_underrun();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
